// File: rtl/utopia_phy_cell_src_if.sv
// Local byte-push and UTOPIA Level-1 Rx-side signal bundle for the PHY cell source.
// master = the cell source itself, slave = the local producer plus the router's Rx port.
interface utopia_phy_cell_src_if;
   logic [7:0] in_data;
   logic       in_sop;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_soc;
   logic       tx_clav;
   logic       tx_en_n;

   modport master (
      input  in_data, in_sop, in_valid, tx_en_n,
      output in_ready, tx_data, tx_soc, tx_clav
   );

   modport slave (
      output in_data, in_sop, in_valid, tx_en_n,
      input  in_ready, tx_data, tx_soc, tx_clav
   );
endinterface

// File: rtl/utopia_phy_cell_src.sv
// UTOPIA L1 PHY cell source: buffers DEPTH 53-byte cells from a local push port, offers only whole cells;
// clav one cycle after the commit edge, zero-wait-state bytes, en_n=1 holds the byte. `UTOPIA_HEC_GEN_EN` regenerates byte 4.
module utopia_phy_cell_src #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   utopia_phy_cell_src_if.master bus,
   output logic [CNT_W-1:0]      cells_sent,
   output logic [CNT_W-1:0]      cells_dropped
);
   localparam int CELL_LEN = 53;
   localparam int SLOT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CMT_W    = $clog2(DEPTH + 1);
   localparam int ADDR_W   = $clog2(DEPTH * CELL_LEN);
   localparam logic [5:0]        LAST_IDX  = 6'd52;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DEPTH - 1);
   localparam logic [CMT_W-1:0]  FULL_CNT  = CMT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] CELL_B    = ADDR_W'(CELL_LEN);

   logic [7:0]        mem_q [DEPTH*CELL_LEN];
   logic [SLOT_W-1:0] wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
   logic [5:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
   logic [CMT_W-1:0]  committed_q, committed_d;
   logic [CNT_W-1:0]  sent_q, sent_d, drop_q, drop_d;
   logic              mem_we, commit, done, wr_acc, xfer, clav;
   logic [5:0]        mem_widx;
   logic [7:0]        mem_wdat;
   logic [ADDR_W-1:0] wr_addr, rd_addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

`ifdef UTOPIA_HEC_GEN_EN
   logic [7:0] crc_q, crc_d;

   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction
`endif

   assign clav         = (committed_q != '0);
   assign bus.in_ready = (committed_q < FULL_CNT);
   assign wr_acc       = bus.in_valid && bus.in_ready;
   assign xfer         = !bus.tx_en_n && clav;
   assign wr_addr      = ADDR_W'(wr_slot_q) * CELL_B + ADDR_W'(mem_widx);
   assign rd_addr      = ADDR_W'(rd_slot_q) * CELL_B + ADDR_W'(rd_idx_q);
   assign bus.tx_clav  = clav;
   assign bus.tx_data  = clav ? mem_q[rd_addr] : 8'h00;
   assign bus.tx_soc   = clav && (rd_idx_q == 6'd0);
   assign cells_sent    = sent_q;
   assign cells_dropped = drop_q;

   always_comb begin
      wr_slot_d   = wr_slot_q;
      wr_idx_d    = wr_idx_q;
      rd_slot_d   = rd_slot_q;
      rd_idx_d    = rd_idx_q;
      committed_d = committed_q;
      sent_d      = sent_q;
      drop_d      = drop_q;
      mem_we      = 1'b0;
      mem_widx    = wr_idx_q;
      mem_wdat    = bus.in_data;
      commit      = 1'b0;
      done        = 1'b0;

      // A sop byte always restarts the current slot; a non-sop byte at index 0 is dropped silently.
      if (wr_acc) begin
         if (bus.in_sop) begin
            if (wr_idx_q != 6'd0) drop_d = sat_inc(drop_q);
            mem_we   = 1'b1;
            mem_widx = 6'd0;
            wr_idx_d = 6'd1;
         end else if (wr_idx_q != 6'd0) begin
            mem_we = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
               commit    = 1'b1;
               wr_idx_d  = 6'd0;
               wr_slot_d = (wr_slot_q == LAST_SLOT) ? '0 : wr_slot_q + 1'b1;
            end else begin
               wr_idx_d = wr_idx_q + 6'd1;
            end
         end
      end

      if (xfer) begin
         if (rd_idx_q == LAST_IDX) begin
            done      = 1'b1;
            rd_idx_d  = 6'd0;
            rd_slot_d = (rd_slot_q == LAST_SLOT) ? '0 : rd_slot_q + 1'b1;
            sent_d    = sat_inc(sent_q);
         end else begin
            rd_idx_d = rd_idx_q + 6'd1;
         end
      end

      if (commit && !done)      committed_d = committed_q + 1'b1;
      else if (!commit && done) committed_d = committed_q - 1'b1;
   end

`ifdef UTOPIA_HEC_GEN_EN
   always_comb begin
      crc_d = crc_q;
      if (mem_we && (mem_widx < 6'd4))
         crc_d = crc8_byte((mem_widx == 6'd0) ? 8'h00 : crc_q, bus.in_data);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) crc_q <= 8'h00;
      else      crc_q <= crc_d;
   end

   // HEC slot takes the running header CRC; the pushed byte only advances the handshake.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_addr] <= (mem_widx == 6'd4) ? (crc_q ^ 8'h55) : mem_wdat;
   end
`else
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_addr] <= mem_wdat;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_slot_q   <= '0;
         wr_idx_q    <= 6'd0;
         rd_slot_q   <= '0;
         rd_idx_q    <= 6'd0;
         committed_q <= '0;
         sent_q      <= '0;
         drop_q      <= '0;
      end else begin
         wr_slot_q   <= wr_slot_d;
         wr_idx_q    <= wr_idx_d;
         rd_slot_q   <= rd_slot_d;
         rd_idx_q    <= rd_idx_d;
         committed_q <= committed_d;
         sent_q      <= sent_d;
         drop_q      <= drop_d;
      end
   end
endmodule

// File: doc/utopia_phy_cell_src.md
Name: utopia_phy_cell_src

Overview:
UTOPIA Level-1 PHY-side cell source that drives one Rx port of the ATM router: it presents data, soc and clav, and samples the router's active-low en.
- A local byte-stream push interface loads cells into a DEPTH-cell buffer.
- Only complete 53-byte cells are offered on the UTOPIA side.
- Used as the bench/PHY model feeding each Rx_*_n port, and as a standalone source in loopback tests.

Parameters:
DEPTH, 4, number of 53-byte cell slots buffered (>=1, power of 2 not required)
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  UTOPIA and local clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
in_data  input  8  local cell byte
in_sop  input  1  marks byte 0 of a cell on the local side
in_valid  input  1  local byte valid
in_ready  output  1  buffer can accept a byte
tx_data  output  8  UTOPIA data to router Rx_data
tx_soc  output  1  UTOPIA start-of-cell, high on byte 0
tx_clav  output  1  UTOPIA cell available
tx_en_n  input  1  UTOPIA enable from router, active-low
cells_sent  output  CNT_W  cells fully transferred on UTOPIA side
cells_dropped  output  CNT_W  partial cells aborted on local side

Behaviour:
- Reset (rst=0, asynchronous):
  - tx_data=0, tx_soc=0, tx_clav=0, counters=0.
  - Buffer is emptied, and write/read byte index and slot pointers go to 0.
  - in_ready=1 as soon as rst=1 (empty buffer).
  - Reset mid-cell discards all content on both sides. No partial cell survives.
- Storage:
  - DEPTH*53-byte array with write slot/byte index (0..52) and read slot/byte index.
  - Slot pointers wrap DEPTH-1 -> 0.
  - committed counter (0..DEPTH) counts complete cells held.
- Local write, accepted when in_valid && in_ready:
  - in_ready = (committed < DEPTH). The slot being written is never a committed slot.
  - Byte index 0 requires in_sop=1. A byte with in_sop=0 at index 0 is discarded and not counted.
  - in_sop=1 at index 1..52: the partial cell is aborted, cells_dropped increments, and this byte is stored as index 0 of the same slot.
  - Writing index 52 commits the cell: committed+1, write slot advances, index returns to 0.
- UTOPIA side (cell-level handshake):
  - tx_clav = (committed != 0). It stays high for the whole cell being read.
  - tx_data/tx_soc always reflect the current read byte with zero wait states. tx_soc=1 only at read index 0.
  - When tx_clav=0: tx_data=0, tx_soc=0.
  - Transfer occurs at a rising edge where tx_en_n=0 && tx_clav=1. The read index then advances, and the next byte appears after that edge.
  - tx_en_n=1 holds the current byte and soc indefinitely. No byte is skipped or repeated.
  - Transfer of index 52: committed-1, read slot advances, cells_sent+1, and tx_clav falls in the same cycle if committed becomes 0.
  - Commit and completion on the same edge leave committed unchanged.
- Latency:
  - The last local byte written at edge N gives tx_clav=1 after edge N (empty buffer case).
  - Back-to-back cells with tx_en_n held low: byte 0 of the next cell follows byte 52 with no gap.
- Counters saturate at all-ones.

Optional Feature:
UTOPIA_HEC_GEN_EN
- Defined: byte 4 (HEC) is not taken from in_data. It is replaced with CRC-8 (poly x^8+x^2+x+1, init 0x00) over bytes 0..3, XOR 0x55.
  - The CRC register updates on each accepted local byte at indices 0..3 and resets at index 0.
  - The in_data value at index 4 is ignored but still consumes a handshake.
- Undefined: byte 4 is stored unchanged.

Test Plan:
- Reset check: hold rst=0 then release -> tx_clav=0, tx_soc=0, tx_data=0x00, in_ready=1, both counters 0.
- Single cell: push bytes 0x00..0x34 (in_sop on 0x00), tx_en_n=0 throughout ->
  - tx_clav=1 the cycle after byte 0x34 is written.
  - 53 transfers 0x00..0x34, with tx_soc=1 only with 0x00.
  - tx_clav=0 after the 0x34 transfer; cells_sent=1.
- Pause: same cell, tx_en_n=1 for 3 cycles while byte 0x0A is presented -> 0x0A held 3 cycles, next transfer is 0x0A, then 0x0B; no loss.
- Full: DEPTH=2, push 3 cells with tx_en_n=1 -> in_ready=0 after the second cell's byte 52. Then drain one cell -> in_ready=1 the cycle after its last transfer; third cell accepted.
- Abort: in_sop=1 asserted at byte index 20 -> cells_dropped=1; only the following complete cell is emitted, and its byte 0 is the sop byte.
- With UTOPIA_HEC_GEN_EN:
  - Header 00 00 00 00 -> byte 4 = 0x55.
  - Header 00 00 00 01 -> byte 4 = 0x52.
  - Without the macro, a pushed 0xAB at index 4 is emitted unchanged.
